// File: rtl/group_stream_arbiter_pkg.sv
// rtl/group_stream_arbiter_pkg.sv - shared state type, default sizes and width helpers
package grp_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        EMIT    = 2'd2
    } state_t;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_GROUP_SIZE = 16;

    // Requester index width; a single requester still needs one bit.
    function automatic int id_width(input int num_req);
        return (num_req <= 1) ? 1 : $clog2(num_req);
    endfunction

    // Counter must be able to hold the value GROUP_SIZE itself.
    function automatic int cnt_width(input int group_size);
        return $clog2(group_size + 1);
    endfunction

endpackage

// File: rtl/group_stream_arbiter_if.sv
// rtl/group_stream_arbiter_if.sv - serial requester and packed-output bundle
interface group_stream_arbiter_if
    import grp_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int GROUP_SIZE = DEF_GROUP_SIZE,
    parameter int ID_W       = id_width(DEF_NUM_REQ)
);
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ-1:0]    bit_valid;
    logic [NUM_REQ-1:0]    bit_in;
    logic [NUM_REQ-1:0]    grant;
    logic                  out_valid;
    logic                  out_ready;
    logic [GROUP_SIZE-1:0] out_data;
    logic [ID_W-1:0]       out_id;
    logic                  abort;

    modport slave (
        input  req, bit_valid, bit_in, out_ready,
        output grant, out_valid, out_data, out_id, abort
    );

    modport master (
        output req, bit_valid, bit_in, out_ready,
        input  grant, out_valid, out_data, out_id, abort
    );
endinterface

// File: rtl/group_stream_arbiter_bit_packer.sv
// rtl/group_stream_arbiter_bit_packer.sv - serial-to-parallel shift register with bit counter
module bit_packer #(
    parameter int GROUP_SIZE = 16,
    parameter int CNT_W      = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  shift_en,
    input  logic                  data_bit,
    output logic [GROUP_SIZE-1:0] shreg,
    output logic [CNT_W-1:0]      count,
    output logic                  full
);

    // High while the bit being shifted in this cycle completes the group.
    assign full = shift_en && (count == CNT_W'(GROUP_SIZE - 1));

    // Shift accepted bits in at the LSB so the first bit ends up in the MSB.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shreg <= '0;
            count <= '0;
        end else begin
            if (shift_en) begin
                shreg <= {shreg[GROUP_SIZE-2:0], data_bit};
            end
            if (clear) begin
                count <= '0;
            end else if (shift_en) begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/group_stream_arbiter.sv
// rtl/group_stream_arbiter.sv - round-robin group arbiter over one packer; GRP_ARB_TIMEOUT_EN adds stall timeout
module group_stream_arbiter
    import grp_arb_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int GROUP_SIZE     = DEF_GROUP_SIZE,
    parameter int CNT_W          = cnt_width(GROUP_SIZE),
    parameter int ID_W           = id_width(NUM_REQ),
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    group_stream_arbiter_if.slave bus
);

    state_t                state;
    logic [ID_W-1:0]       rr_ptr;
    logic [ID_W-1:0]       grant_idx;
    logic [ID_W-1:0]       win_idx;
    logic [ID_W-1:0]       cand_idx;
    logic                  win_found;
    logic                  req_g;
    logic                  bit_g;
    logic                  shift_en;
    logic                  pk_clear;
    logic                  pk_full;
    logic                  timeout;
    logic [GROUP_SIZE-1:0] shreg;
    logic [CNT_W-1:0]      unused_bit_count;
    logic                  unused_shreg_msb;

    assign req_g    = bus.req[grant_idx];
    assign bit_g    = bus.bit_in[grant_idx];
    assign shift_en = (state == COLLECT) && req_g && bus.bit_valid[grant_idx];
    assign pk_clear = (state == COLLECT) && (!req_g || timeout || pk_full);
    assign unused_shreg_msb = shreg[GROUP_SIZE-1];

    bit_packer #(
        .GROUP_SIZE(GROUP_SIZE),
        .CNT_W     (CNT_W)
    ) u_packer (
        .clock   (clock),
        .reset   (reset),
        .clear   (pk_clear),
        .shift_en(shift_en),
        .data_bit(bit_g),
        .shreg   (shreg),
        .count   (unused_bit_count),
        .full    (pk_full)
    );

`ifdef GRP_ARB_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [STALL_W-1:0] stall_cnt;

    // Fires on the TIMEOUT_CYCLES-th consecutive collect cycle without a bit.
    assign timeout = (state == COLLECT) && !shift_en
                     && (stall_cnt == STALL_W'(TIMEOUT_CYCLES - 1));

    // Count consecutive idle collect cycles; any accepted bit or exit restarts it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if ((state != COLLECT) || shift_en || pk_clear) begin
            stall_cnt <= '0;
        end else begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    // Round-robin search starting just above the last winner, with wrap.
    always_comb begin
        win_found = 1'b0;
        win_idx   = rr_ptr;
        cand_idx  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand_idx = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (!win_found && bus.req[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    // Arbiter FSM; all handshake outputs are registered here.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            rr_ptr        <= ID_W'(NUM_REQ - 1);
            grant_idx     <= '0;
            bus.grant     <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_id    <= '0;
            bus.abort     <= 1'b0;
        end else begin
            bus.abort <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        bus.grant <= NUM_REQ'(1) << win_idx;
                        grant_idx <= win_idx;
                        rr_ptr    <= win_idx;
                        state     <= COLLECT;
                    end
                end
                COLLECT: begin
                    // A dropped request wins over a bit strobed in the same cycle.
                    if (!req_g || timeout) begin
                        bus.abort <= 1'b1;
                        bus.grant <= '0;
                        state     <= IDLE;
                    end else if (pk_full) begin
                        bus.out_data  <= {shreg[GROUP_SIZE-2:0], bit_g};
                        bus.out_id    <= grant_idx;
                        bus.out_valid <= 1'b1;
                        bus.grant     <= '0;
                        state         <= EMIT;
                    end
                end
                EMIT: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_group_stream_arbiter.sv
// tb/tb_group_stream_arbiter.sv - directed bench for group_stream_arbiter; GRP_ARB_TIMEOUT_EN adds timeout sequences
module tb_group_stream_arbiter;

    localparam int NUM_REQ        = 4;
    localparam int GROUP_SIZE     = 16;
    localparam int ID_W           = 2;
    localparam int TIMEOUT_CYCLES = 8;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    group_stream_arbiter_if #(
        .NUM_REQ   (NUM_REQ),
        .GROUP_SIZE(GROUP_SIZE),
        .ID_W      (ID_W)
    ) bus ();

    group_stream_arbiter #(
        .NUM_REQ       (NUM_REQ),
        .GROUP_SIZE    (GROUP_SIZE),
        .ID_W          (ID_W),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  bv;
        logic [3:0]  bi;
        logic        rdy;
        logic [3:0]  grant;
        logic        valid;
        logic [15:0] data;
        logic [1:0]  id;
        logic        abort;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] rq, input logic [3:0] bv, input logic [3:0] bi,
                        input logic rdy, input logic [3:0] g, input logic v,
                        input logic [15:0] d, input logic [1:0] id, input logic ab);
        vec_t t;
        t.req = rq; t.bv = bv; t.bi = bi; t.rdy = rdy;
        t.grant = g; t.valid = v; t.data = d; t.id = id; t.abort = ab;
        vecs.push_back(t);
    endtask

    // Wait (bounded) for a grant, then stream one word MSB first at one bit per cycle.
    task automatic send_group(input string name, input int r, input logic [15:0] w);
        int n;
        n = 0;
        while (bus.grant == 4'b0000 && n < 10) begin
            @(negedge clock);
            n++;
        end
        check({name, "_grant"}, bus.grant, 32'(4'b0001 << r));
        for (int k = 0; k < 16; k++) begin
            bus.bit_valid = 4'b1111;
            bus.bit_in    = {4{w[15-k]}};
            @(negedge clock);
        end
        check({name, "_valid"}, bus.out_valid, 1);
        check({name, "_data"}, bus.out_data, w);
        check({name, "_id"}, bus.out_id, r);
    endtask

    // Structural invariants sampled every cycle out of reset.
    always @(negedge clock) begin
        if (reset === 1'b0) begin
            checks++;
            if (!$onehot0(bus.grant) || (bus.out_valid && bus.grant != 4'b0000)) begin
                errors++;
                $display("FAIL invariant: grant %b out_valid %b", bus.grant, bus.out_valid);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        logic [15:0] w1;
        logic [15:0] rr_words [4];
        vec_t        v;
        logic        b;

        rr_words[0] = 16'h1234;
        rr_words[1] = 16'h5678;
        rr_words[2] = 16'h9ABC;
        rr_words[3] = 16'hDEF0;

        // Single requester 1 streaming 16'hAC35 with noise on the other lanes.
        w1 = 16'hAC35;
        push(4'b0010, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 16'h0000, 2'd0, 1'b0);
        for (int k = 0; k < 16; k++) begin
            b = w1[15-k];
            push(4'b0010, 4'b1111, {~b, ~b, b, ~b}, 1'b1, 4'b0010, 1'b0, 16'h0000, 2'd0, 1'b0);
        end
        push(4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 16'hAC35, 2'd1, 1'b0);
        push(4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 16'h0000, 2'd0, 1'b0);
        // Gapped stream from requester 0: 16 ones over 31 cycles, zeros on idle cycles.
        push(4'b0001, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 16'h0000, 2'd0, 1'b0);
        for (int k = 0; k < 31; k++) begin
            if (k % 2 == 0)
                push(4'b0001, 4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b0, 16'h0000, 2'd0, 1'b0);
            else
                push(4'b0001, 4'b0000, 4'b0000, 1'b1, 4'b0001, 1'b0, 16'h0000, 2'd0, 1'b0);
        end
        push(4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 16'hFFFF, 2'd0, 1'b0);
        push(4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 16'h0000, 2'd0, 1'b0);

        bus.req       = 4'b0000;
        bus.bit_valid = 4'b0000;
        bus.bit_in    = 4'b0000;
        bus.out_ready = 1'b0;
        reset         = 1'b1;
        repeat (2) @(negedge clock);
        check("reset_grant", bus.grant, 0);
        check("reset_valid", bus.out_valid, 0);
        check("reset_data", bus.out_data, 0);
        check("reset_id", bus.out_id, 0);
        check("reset_abort", bus.abort, 0);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clock);
            v = vecs[i];
            check($sformatf("vec%0d_grant", i), bus.grant, v.grant);
            check($sformatf("vec%0d_valid", i), bus.out_valid, v.valid);
            check($sformatf("vec%0d_abort", i), bus.abort, v.abort);
            if (v.valid) begin
                check($sformatf("vec%0d_data", i), bus.out_data, v.data);
                check($sformatf("vec%0d_id", i), bus.out_id, v.id);
            end
            bus.req       = v.req;
            bus.bit_valid = v.bv;
            bus.bit_in    = v.bi;
            bus.out_ready = v.rdy;
        end

        // Round robin from reset: all four request continuously, three rounds.
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset         = 1'b0;
        bus.req       = 4'b1111;
        bus.bit_valid = 4'b1111;
        bus.out_ready = 1'b1;
        for (int g = 0; g < 12; g++) begin
            send_group($sformatf("rr%0d", g), g % 4, rr_words[g % 4]);
        end
        bus.req = 4'b0000;
        @(negedge clock);

        // Abort: requester 2 drops after 7 bits while strobing; requester 3 is next.
        bus.req = 4'b0100;
        @(negedge clock);
        check("abort_grant2", bus.grant, 4'b0100);
        bus.bit_in = 4'b1111;
        repeat (7) @(negedge clock);
        bus.req = 4'b1011;
        @(negedge clock);
        check("abort_pulse", bus.abort, 1);
        check("abort_grant_drop", bus.grant, 0);
        check("abort_no_valid", bus.out_valid, 0);
        bus.req = 4'b1000;
        @(negedge clock);
        check("abort_pulse_end", bus.abort, 0);
        send_group("abort_next", 3, 16'h0F5A);
        bus.req = 4'b0000;
        @(negedge clock);

        // Back-pressure: output held for 10 cycles with requester 1 pending.
        bus.req       = 4'b0011;
        bus.out_ready = 1'b0;
        send_group("bp", 0, 16'h3C96);
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            check($sformatf("bp_hold%0d_valid", c), bus.out_valid, 1);
            check($sformatf("bp_hold%0d_data", c), bus.out_data, 16'h3C96);
            check($sformatf("bp_hold%0d_grant", c), bus.grant, 0);
        end
        bus.out_ready = 1'b1;
        @(negedge clock);
        check("bp_release_valid", bus.out_valid, 0);
        check("bp_release_grant", bus.grant, 0);
        @(negedge clock);
        check("bp_next_grant", bus.grant, 4'b0010);

        // Reset in the middle of a group clears everything asynchronously.
        bus.req = 4'b0010;
        repeat (3) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("midreset_grant", bus.grant, 0);
        check("midreset_valid", bus.out_valid, 0);
        check("midreset_data", bus.out_data, 0);
        check("midreset_abort", bus.abort, 0);
        @(negedge clock);
        reset   = 1'b0;
        bus.req = 4'b1111;
        @(negedge clock);
        check("midreset_rr_first", bus.grant, 4'b0001);

`ifdef GRP_ARB_TIMEOUT_EN
        // Requester 0 granted: 3 bits, 7-cycle stall then a bit, then an 8-cycle stall.
        bus.req       = 4'b0011;
        bus.bit_valid = 4'b1111;
        repeat (3) @(negedge clock);
        bus.bit_valid = 4'b0000;
        for (int s = 0; s < 7; s++) begin
            @(negedge clock);
            check($sformatf("to_short%0d_abort", s), bus.abort, 0);
        end
        bus.bit_valid = 4'b1111;
        @(negedge clock);
        check("to_short_grant", bus.grant, 4'b0001);
        bus.bit_valid = 4'b0000;
        for (int s = 0; s < 7; s++) begin
            @(negedge clock);
            check($sformatf("to_long%0d_abort", s), bus.abort, 0);
        end
        @(negedge clock);
        check("to_abort", bus.abort, 1);
        check("to_grant_drop", bus.grant, 0);
        @(negedge clock);
        check("to_next_grant", bus.grant, 4'b0010);
`endif

        bus.req       = 4'b0000;
        bus.bit_valid = 4'b0000;
        repeat (3) @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
